// File: rtl/systemizer_pkg.sv
// -----------------------------------------------------------------------------
// systemizer_pkg
// Shared constants for the systemizer job controller and its output FIFO:
// matrix geometry, derived word/address widths and the controller state
// encoding. CLOG2 is provided here so that the derived widths can be
// evaluated as constants at elaboration time.
// -----------------------------------------------------------------------------
package systemizer_pkg;

    // Ceiling log2 for elaboration-time width derivation (CLOG2(1) = 0)
    function automatic int CLOG2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int N     = 4;            // elements per memory word
    localparam int M     = 3;            // field size
    localparam int L     = 16;           // matrix rows
    localparam int K     = 24;           // matrix columns
    localparam int EW    = CLOG2(M);     // element width
    localparam int W     = N * EW;       // data width
    localparam int WORDS = L * K / N;    // words per matrix
    localparam int A     = CLOG2(WORDS); // address width
    localparam int CNT_W = A + 1;        // counters never wrap within a job

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_WORDS = CNT_W'(WORDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4
    } state_e;

endpackage

// File: rtl/sys_out_fifo.sv
// -----------------------------------------------------------------------------
// sys_out_fifo
// Two-entry result FIFO, W+1 bits wide (data plus last flag).
// Ports:
//   clk, rst (synchronous, active-low)
//   i_in_valid / o_in_ready / i_in_data   : write side
//   o_out_valid / i_out_ready / o_out_data : read side (head, zero when empty)
//   o_occupancy                             : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module sys_out_fifo
    import systemizer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W:0]   i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W:0]   o_out_data,
    output logic [1:0]   o_occupancy
);

    logic [W:0] r_mem [0:1];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign o_occupancy = r_count;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = o_out_valid && i_out_ready;

    // Head presentation; a drained FIFO shows zero rather than a stale entry
    always_comb begin
        o_out_data = '0;
        if (o_out_valid) begin
            o_out_data = r_mem[r_rd_ptr];
        end else begin
            o_out_data = '0;
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/systemizer_ctrl.sv
// -----------------------------------------------------------------------------
// systemizer_ctrl
// Job controller around the systemizer elimination engine: loads one matrix
// into the engine, starts it, waits for done/fail and streams the result out.
// Ports:
//   clk, rst (synchronous, active-low)
//   in_valid / in_ready / in_data          : matrix input stream, word 0 first
//   sys_start, sys_done, sys_fail           : engine control/status
//   sys_wr_en / sys_wr_addr / sys_wr_data   : engine write port
//   sys_rd_en / sys_rd_addr / sys_rd_data   : engine read port (1-cycle latency)
//   out_valid / out_ready / out_data / out_last : result stream
//   busy, job_done, job_fail                : job status
// Optional feature, macro SYSTEMIZER_CTRL_CYCLES_EN: adds run_cycles[31:0],
// the number of cycles spent waiting on the engine for the latest job.
// -----------------------------------------------------------------------------
module systemizer_ctrl
    import systemizer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         sys_start,
    input  logic         sys_done,
    input  logic         sys_fail,
    output logic         sys_wr_en,
    output logic [A-1:0] sys_wr_addr,
    output logic [W-1:0] sys_wr_data,
    output logic         sys_rd_en,
    output logic [A-1:0] sys_rd_addr,
    input  logic [W-1:0] sys_rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         job_done,
    output logic         job_fail
`ifdef SYSTEMIZER_CTRL_CYCLES_EN
    ,
    output logic [31:0]  run_cycles
`endif
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic               r_rd_pending;
    logic               r_rd_last;
    logic               r_in_ready;
    logic               r_sys_start;
    logic               r_job_done;
    logic               r_job_fail;

    logic               w_in_hs;
    logic               w_out_hs;
    logic               w_rd_issue;
    logic [2:0]         w_credit;
    logic               w_fifo_in_ready;
    logic               w_fifo_push;
    logic               w_fifo_valid;
    logic [W:0]         w_fifo_out;
    logic [1:0]         w_fifo_occ;

    assign in_ready  = r_in_ready;
    assign sys_start = r_sys_start;
    assign job_done  = r_job_done;
    assign job_fail  = r_job_fail;
    assign busy      = (r_state != ST_IDLE);

    assign w_in_hs  = in_valid && r_in_ready;
    assign w_out_hs = w_fifo_valid && out_ready;

    // Slots committed = stored + in flight, less the entry leaving this cycle.
    // Crediting the same-cycle pop is what lets a 2-entry FIFO sustain one
    // word per cycle against the 1-cycle read latency.
    assign w_credit   = {1'b0, w_fifo_occ} + {2'b00, r_rd_pending} - {2'b00, w_out_hs};
    assign w_rd_issue = (r_state == ST_UNLOAD) && (w_credit < 3'd2) && (r_rd_cnt < CNT_WORDS);

    assign sys_rd_en   = w_rd_issue;
    assign sys_rd_addr = w_rd_issue ? r_rd_cnt[A-1:0] : '0;

    // Engine write port: input handshake passes straight through to memory
    always_comb begin
        sys_wr_en   = 1'b0;
        sys_wr_addr = '0;
        sys_wr_data = '0;
        if (w_in_hs) begin
            sys_wr_en   = 1'b1;
            sys_wr_data = in_data;
            if (r_state == ST_LOAD) begin
                sys_wr_addr = r_wr_cnt[A-1:0];
            end else begin
                sys_wr_addr = '0;
            end
        end else begin
            sys_wr_en = 1'b0;
        end
    end

    // Read data is captured on the edge after it arrives; a reset clears the
    // pending flag so late data from an aborted job is dropped.
    assign w_fifo_push = r_rd_pending && w_fifo_in_ready;

    sys_out_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_fifo_push),
        .o_in_ready  (w_fifo_in_ready),
        .i_in_data   ({r_rd_last, sys_rd_data}),
        .o_out_valid (w_fifo_valid),
        .i_out_ready (out_ready),
        .o_out_data  (w_fifo_out),
        .o_occupancy (w_fifo_occ)
    );

    assign out_valid = w_fifo_valid;
    assign out_data  = w_fifo_out[W-1:0];
    assign out_last  = w_fifo_out[W];

    // Job state machine with its counters and registered status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_last    <= 1'b0;
            r_in_ready   <= 1'b1;
            r_sys_start  <= 1'b0;
            r_job_done   <= 1'b0;
            r_job_fail   <= 1'b0;
        end else begin
            r_sys_start  <= 1'b0;
            r_job_done   <= 1'b0;
            r_job_fail   <= 1'b0;
            r_rd_pending <= w_rd_issue;
            r_rd_last    <= w_rd_issue && (r_rd_cnt == CNT_LAST);
            if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_in_hs) begin
                        r_state  <= ST_LOAD;
                        r_wr_cnt <= CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    if (w_in_hs) begin
                        r_wr_cnt <= r_wr_cnt + CNT_ONE;
                        if (r_wr_cnt == CNT_LAST) begin
                            r_state     <= ST_START;
                            r_in_ready  <= 1'b0;
                            r_sys_start <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sys_fail) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_job_done <= 1'b1;
                        r_job_fail <= 1'b1;
                    end else if (sys_done) begin
                        r_state  <= ST_UNLOAD;
                        r_rd_cnt <= '0;
                    end
                end
                ST_UNLOAD: begin
                    if (w_out_hs && w_fifo_out[W]) begin
                        r_state    <= ST_IDLE;
                        r_in_ready <= 1'b1;
                        r_job_done <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SYSTEMIZER_CTRL_CYCLES_EN
    logic [31:0] r_run_cycles;

    // Engine run time: cleared by the start pulse, counts WAIT cycles, saturates
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run_cycles <= 32'd0;
        end else if (r_sys_start) begin
            r_run_cycles <= 32'd0;
        end else if ((r_state == ST_WAIT) && (r_run_cycles != 32'hFFFF_FFFF)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end else begin
            r_run_cycles <= r_run_cycles;
        end
    end

    assign run_cycles = r_run_cycles;
`endif

endmodule

// File: tb/tb_systemizer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systemizer_ctrl
// Directed bench for systemizer_ctrl with a behavioural engine memory model.
// The engine returns stored word XOR 8'h5A so results must come via the read
// path. Jobs: clean load/unload, gapped input with throttled output, fail,
// reset mid-unload, recovery job and an output stall at unload entry.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systemizer_ctrl;

    localparam int NW = 96;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       sys_done = 1'b0;
    logic       sys_fail = 1'b0;
    logic [7:0] sys_rd_data = 8'd0;
    logic       out_ready = 1'b0;

    logic       in_ready, sys_start, sys_wr_en, sys_rd_en;
    logic [6:0] sys_wr_addr, sys_rd_addr;
    logic [7:0] sys_wr_data, out_data;
    logic       out_valid, out_last, busy, job_done, job_fail;
`ifdef SYSTEMIZER_CTRL_CYCLES_EN
    logic [31:0] run_cycles;
`endif

    systemizer_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sys_start(sys_start), .sys_done(sys_done), .sys_fail(sys_fail),
        .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data),
        .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_rd_data(sys_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .job_done(job_done), .job_fail(job_fail)
`ifdef SYSTEMIZER_CTRL_CYCLES_EN
        , .run_cycles(run_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // monitor state (written only by the monitor)
    logic [7:0] eng_mem [128];
    int cyc = 0, wr_cnt = 0, wr_bad = 0, last_wr_cyc = 0, start_cnt = 0, start_cyc = 0;
    int rd_cnt = 0, overlap = 0, out_cnt = 0, data_bad = 0, last_bad = 0, stab_bad = 0;
    int done_cnt = 0, done_cyc = 0, fail_cnt = 0, fail_alone = 0, idx = 0;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = 8'd0;

    // per-job context (written only by the stimulus)
    logic [7:0] exp_d [NW];
    int wr_base = 0, out_base = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Engine read port: one-cycle latency, sentinel when idle
    always @(posedge clk) begin
        if (sys_rd_en) sys_rd_data <= eng_mem[sys_rd_addr] ^ 8'h5A;
        else           sys_rd_data <= 8'hEE;
    end

    // Monitor sampled mid-cycle
    always @(negedge clk) begin
        if (sys_wr_en) begin
            if (int'(sys_wr_addr) != wr_cnt - wr_base) wr_bad++;
            eng_mem[sys_wr_addr] = sys_wr_data;
            if (sys_wr_addr == 7'd95) last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (sys_start) begin start_cnt++; start_cyc = cyc; end
        if (sys_rd_en) rd_cnt++;
        if (sys_wr_en && sys_rd_en) overlap++;
        if (prev_v && !prev_r && (!out_valid || out_data != prev_d || out_last != prev_l)) stab_bad++;
        if (out_valid && out_ready) begin
            idx = out_cnt - out_base;
            if (idx < 0 || idx >= NW || out_data != exp_d[idx]) data_bad++;
            if (out_last != (idx == NW - 1)) last_bad++;
            out_cnt++;
        end
        if (job_done) begin done_cnt++; done_cyc = cyc; end
        if (job_fail) fail_cnt++;
        if (job_fail && !job_done) fail_alone++;
        prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
        cyc++;
    end

    task automatic check_reset_vals(input string p);
        // in_ready busy sys_start wr_en rd_en out_valid out_last job_done job_fail
        chk({p, "_ctl"}, int'({in_ready, busy, sys_start, sys_wr_en, sys_rd_en,
                               out_valid, out_last, job_done, job_fail}), 256);
        chk({p, "_out_data"}, int'(out_data), 0);
        chk({p, "_rd_addr"}, int'(sys_rd_addr), 0);
    endtask

    // mode: 0 = out_ready high, 1 = 30% random, 2 = low for 10 cycles at unload
    task automatic run_job(input bit gaps, input int base, input int mode,
                           input int abort_at, input bit fail_job);
        int w0, wb0, s0, r0, o0, d0, f0, fa0, db0, lb0, sb0, ov0;
        int i, k, first_ov;
        bit hs, seen_ov, aborted;
        for (int j = 0; j < NW; j++) exp_d[j] = 8'(j + base) ^ 8'h5A;
        wr_base = wr_cnt; out_base = out_cnt;
        w0 = wr_cnt; wb0 = wr_bad; s0 = start_cnt; r0 = rd_cnt; o0 = out_cnt;
        d0 = done_cnt; f0 = fail_cnt; fa0 = fail_alone; db0 = data_bad;
        lb0 = last_bad; sb0 = stab_bad; ov0 = overlap;
        out_ready = (mode == 0);
        i = 0; k = 0;
        while (i < NW && k < 1000) begin
            in_valid = gaps ? ($urandom_range(1, 0) == 1) : 1'b1;
            in_data  = 8'(i + base);
            @(negedge clk); hs = in_valid && in_ready;
            @(posedge clk); #1; k++;
            if (hs) i++;
        end
        in_valid = 1'b0;
        chk("load_hs", i, NW);
        k = 0;
        while (!sys_start && k < 10) begin @(posedge clk); #1; k++; end
        chk("start_seen", int'(sys_start), 1);
        repeat (fail_job ? 20 : 50) @(posedge clk);
        #1; sys_done = 1'b1; sys_fail = fail_job;
        @(posedge clk); #1; sys_done = 1'b0; sys_fail = 1'b0;
        seen_ov = 1'b0; first_ov = 0; aborted = 1'b0; k = 0;
        while (done_cnt == d0 && k < 2000) begin
            if (out_valid && !seen_ov) begin seen_ov = 1'b1; first_ov = cyc; end
            if (mode == 2 && k == 10) begin
                chk("stall_rd", rd_cnt - r0, 2);
                chk("stall_occ", int'(dut.w_fifo_occ), 2);
                chk("stall_valid", int'(out_valid), 1);
            end
            if (abort_at > 0 && out_cnt - o0 >= abort_at) begin
                rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
                check_reset_vals("mid_rst");
                aborted = 1'b1;
                break;
            end
            case (mode)
                1: out_ready = ($urandom_range(9, 0) < 3);
                2: out_ready = (k >= 10);
                default: out_ready = 1'b1;
            endcase
            @(posedge clk); #1; k++;
        end
        if (!aborted) begin
            chk("done_cnt", done_cnt - d0, 1);
            chk("fail_cnt", fail_cnt - f0, fail_job ? 1 : 0);
            chk("fail_alone", fail_alone - fa0, 0);
            chk("wr_cnt", wr_cnt - w0, NW);
            chk("wr_addr", wr_bad - wb0, 0);
            chk("start_cnt", start_cnt - s0, 1);
            chk("start_lat", start_cyc - last_wr_cyc, 1);
            chk("wr_rd_overlap", overlap - ov0, 0);
            chk("idle_ready", int'(in_ready), 1);
            chk("idle_busy", int'(busy), 0);
            if (fail_job) begin
                chk("fail_rd", rd_cnt - r0, 0);
                chk("fail_out", out_cnt - o0, 0);
                chk("fail_lat", done_cyc - start_cyc, 21);
            end else begin
                chk("rd_cnt", rd_cnt - r0, NW);
                chk("out_cnt", out_cnt - o0, NW);
                chk("out_data", data_bad - db0, 0);
                chk("out_last", last_bad - lb0, 0);
                chk("out_stable", stab_bad - sb0, 0);
                if (mode == 0) begin
                    chk("first_valid_lat", first_ov - start_cyc, 53);
                    chk("done_lat", done_cyc - start_cyc, 149);
                end
            end
        end
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        rst = 1'b1;
        run_job(1'b0, 0, 0, 0, 1'b0);
`ifdef SYSTEMIZER_CTRL_CYCLES_EN
        chk("run_cycles", int'(run_cycles), 50);
        repeat (4) @(posedge clk);
        #1;
        chk("run_cycles_hold", int'(run_cycles), 50);
`endif
        run_job(1'b1, 8'h80, 1, 0, 1'b0);
        run_job(1'b0, 8'h10, 0, 0, 1'b1);
        run_job(1'b0, 8'h20, 0, 40, 1'b0);
        run_job(1'b0, 8'h33, 0, 0, 1'b0);
        run_job(1'b0, 8'h44, 2, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
